prio_scan_enc: RTL and testbench
================================

Name: prio_scan_enc

Overview:
- Parametrised, sequential successor to the 8-to-3 priority encoder.
- Accepts a WIDTH-bit request vector through a valid/ready handshake.
- Emits the index of every set bit, one per accepted output beat, in priority order.
- Sits between interrupt/request collectors and downstream servicing logic that handles one request index per transaction.

Parameters:
- WIDTH, 8, request vector width; legal range 2..64.
- IDX_W, 3, index width; must equal ceil(log2(WIDTH)).
- LSB_FIRST, 0, 0 = highest set bit has priority (MSB first); 1 = lowest set bit first.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request vector offered.
- in_ready  output  1  block can accept a vector.
- in_vec  input  WIDTH  request vector.
- flush  input  1  synchronous abort of the current scan.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  downstream accepts the current index.
- out_idx  output  IDX_W  index of the current highest-priority pending bit.
- out_last  output  1  current index is the final pending bit.
- zero_det  output  1  one-cycle pulse: an all-zero vector was accepted.
- pend_cnt  output  IDX_W+1  number of bits still pending, including the current one.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pending register=0.
  - in_ready=1, out_valid=0, out_idx=0, out_last=0, zero_det=0, pend_cnt=0.
  - Reset mid-scan discards all pending bits immediately.
- States: IDLE, SCAN.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid, capture in_vec at the clock edge.
  - Non-zero vector: pending<=in_vec, go to SCAN.
  - Zero vector: zero_det=1 for the next cycle only, remain in IDLE.
  - zero_det is 0 in every other cycle.
- SCAN:
  - in_ready=0; in_vec and in_valid are ignored.
  - out_valid=1.
  - out_idx = priority index of pending: highest set bit if LSB_FIRST=0, lowest if 1.
  - out_last=1 iff pending has exactly one bit set.
  - pend_cnt = popcount(pending).
  - out_idx, out_last and pend_cnt are combinational from the pending register.
  - On out_valid && out_ready: clear bit out_idx in pending. If out_last, go to IDLE next cycle.
  - Without out_ready: outputs hold stable (no change while stalled).
- Latency:
  - Vector accepted at edge N; first index is valid in the cycle after edge N.
  - One index per cycle under continuous out_ready.
  - A vector with k set bits occupies k cycles of SCAN.
  - in_ready returns 1 the cycle after the last beat.
- flush: in SCAN, pending<=0 and state<=IDLE at the next edge.
  - A beat presented in the same cycle as flush counts as accepted if out_ready=1.
  - flush in IDLE: no effect, and an in_valid in that cycle is still accepted.
- Out-of-range bits: only bits [WIDTH-1:0] exist.
  - out_idx never exceeds WIDTH-1.
  - pend_cnt max = WIDTH, which fits in IDX_W+1 bits.
- Outside SCAN: out_idx=0, out_last=0, pend_cnt=0.

Test Plan:
- Reset mid-scan: load 8'b1010_0000, accept one beat, assert rst_n=0 asynchronously -> out_valid drops immediately; after release in_ready=1, pend_cnt=0.
- MSB-first scan, LSB_FIRST=0, WIDTH=8: load 8'b1001_0110 with out_ready=1 ->
  - out_idx sequence 7,4,2,1 on consecutive cycles.
  - pend_cnt 4,3,2,1; out_last only on idx 1.
  - in_ready=1 the following cycle.
- Backpressure: load 8'b0000_0011, hold out_ready=0 for 3 cycles, then 1 -> out_idx=1 stable for 4 cycles, then 0 with out_last=1.
- Zero vector: load 8'h00 -> zero_det=1 for exactly one cycle, out_valid never asserts, in_ready stays 1.
- LSB_FIRST=1, WIDTH=16: load 16'h8001 -> out_idx 0 then 15; out_last on 15.
- Flush: load 8'hFF, accept 2 beats (7,6), assert flush with out_ready=0 -> next cycle IDLE, out_valid=0, pend_cnt=0; a following load of 8'h01 yields out_idx=0 with out_last=1.

Source files
------------

// File: rtl/prio_scan_enc.sv
// Sequential priority encoder: accepts a request vector and returns the index of
// each set bit, one per accepted output beat, in priority order.
module prio_scan_enc #(
    parameter int WIDTH     = 8,
    parameter int IDX_W     = 3,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_det,
    output logic [IDX_W:0]   pend_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] pend_r;
    logic [WIDTH-1:0] pend_next_s;
    logic             zero_det_r;
    logic             zero_det_next_s;
    logic [IDX_W-1:0] cur_idx_s;
    logic [IDX_W:0]   cur_cnt_s;
    logic             cur_last_s;
    logic [WIDTH-1:0] cur_mask_s;

    // Index of the winning bit; later loop iterations overwrite earlier ones.
    function automatic logic [IDX_W-1:0] prio_index(input logic [WIDTH-1:0] vec);
        logic [IDX_W-1:0] idx;
        int               j;
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            j   = (LSB_FIRST == 0) ? i : (WIDTH - 1 - i);
            idx = vec[j] ? j[IDX_W-1:0] : idx;
        end
        return idx;
    endfunction

    function automatic logic [IDX_W:0] pop_count(input logic [WIDTH-1:0] vec);
        logic [IDX_W:0] cnt;
        cnt = {(IDX_W + 1){1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {{IDX_W{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // Decode of the pending register into the current beat.
    always_comb begin
        cur_idx_s  = prio_index(pend_r);
        cur_cnt_s  = pop_count(pend_r);
        cur_last_s = (cur_cnt_s == {{IDX_W{1'b0}}, 1'b1});
        cur_mask_s = {{(WIDTH - 1){1'b0}}, 1'b1} << cur_idx_s;
    end

    // Next-state and pending-register update.
    always_comb begin
        state_next_s    = state_r;
        pend_next_s     = pend_r;
        zero_det_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if (|in_vec) begin
                        pend_next_s  = in_vec;
                        state_next_s = SCAN;
                    end else begin
                        zero_det_next_s = 1'b1;
                    end
                end else begin
                    pend_next_s = {WIDTH{1'b0}};
                end
            end
            SCAN: begin
                if (out_ready) begin
                    pend_next_s = pend_r & ~cur_mask_s;
                end else begin
                    pend_next_s = pend_r;
                end
                // flush still lets a same-cycle accepted beat count, then drops the rest.
                if (flush) begin
                    pend_next_s  = {WIDTH{1'b0}};
                    state_next_s = IDLE;
                end else if (out_ready && cur_last_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SCAN;
                end
            end
            default: begin
                pend_next_s  = {WIDTH{1'b0}};
                state_next_s = IDLE;
            end
        endcase
    end

    // State, pending bits and zero-vector pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pend_r     <= {WIDTH{1'b0}};
            zero_det_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            pend_r     <= pend_next_s;
            zero_det_r <= zero_det_next_s;
        end
    end

    // Output drive; beat fields are forced to zero outside SCAN.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        out_idx   = {IDX_W{1'b0}};
        out_last  = 1'b0;
        pend_cnt  = {(IDX_W + 1){1'b0}};
        zero_det  = zero_det_r;
        if (state_r == SCAN) begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
            out_idx   = cur_idx_s;
            out_last  = cur_last_s;
            pend_cnt  = cur_cnt_s;
        end else begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_prio_scan_enc.sv
// Directed bench for prio_scan_enc: an MSB-first 8-bit instance and an
// LSB-first 16-bit instance driven from one linear stimulus sequence.
module tb_prio_scan_enc;

    logic        clk;
    logic        rst_n;

    logic        in_valid8, in_ready8, flush8, out_valid8, out_ready8, out_last8, zero_det8;
    logic [7:0]  in_vec8;
    logic [2:0]  out_idx8;
    logic [3:0]  pend_cnt8;

    logic        in_valid16, in_ready16, flush16, out_valid16, out_ready16, out_last16, zero_det16;
    logic [15:0] in_vec16;
    logic [3:0]  out_idx16;
    logic [4:0]  pend_cnt16;

    int passed;
    int total;

    prio_scan_enc #(.WIDTH(8), .IDX_W(3), .LSB_FIRST(0)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_vec(in_vec8), .flush(flush8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_idx(out_idx8),
        .out_last(out_last8), .zero_det(zero_det8), .pend_cnt(pend_cnt8)
    );

    prio_scan_enc #(.WIDTH(16), .IDX_W(4), .LSB_FIRST(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_vec(in_vec16), .flush(flush16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_idx(out_idx16),
        .out_last(out_last16), .zero_det(zero_det16), .pend_cnt(pend_cnt16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat8(input string tag, input logic [31:0] idx,
                               input logic [31:0] cnt, input logic [31:0] last);
        check({tag, "_valid"}, 32'(out_valid8), 32'd1);
        check({tag, "_idx"},   32'(out_idx8),   idx);
        check({tag, "_cnt"},   32'(pend_cnt8),  cnt);
        check({tag, "_last"},  32'(out_last8),  last);
        check({tag, "_rdy"},   32'(in_ready8),  32'd0);
    endtask

    task automatic check_idle8(input string tag);
        check({tag, "_valid"}, 32'(out_valid8), 32'd0);
        check({tag, "_rdy"},   32'(in_ready8),  32'd1);
        check({tag, "_idx"},   32'(out_idx8),   32'd0);
        check({tag, "_cnt"},   32'(pend_cnt8),  32'd0);
        check({tag, "_last"},  32'(out_last8),  32'd0);
    endtask

    initial begin
        logic [31:0] exp_idx [4];
        logic [31:0] exp_cnt [4];
        passed = 0;
        total  = 0;
        rst_n = 1'b0;
        in_valid8 = 1'b0; in_vec8 = 8'h00; flush8 = 1'b0; out_ready8 = 1'b0;
        in_valid16 = 1'b0; in_vec16 = 16'h0000; flush16 = 1'b0; out_ready16 = 1'b0;

        // Reset values
        #1;
        check_idle8("rst");
        check("rst_zero", 32'(zero_det8), 32'd0);
        check("rst16_valid", 32'(out_valid16), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check_idle8("post_rst");

        // MSB-first scan of 1001_0110
        exp_idx[0] = 32'd7; exp_idx[1] = 32'd4; exp_idx[2] = 32'd2; exp_idx[3] = 32'd1;
        exp_cnt[0] = 32'd4; exp_cnt[1] = 32'd3; exp_cnt[2] = 32'd2; exp_cnt[3] = 32'd1;
        in_valid8 = 1'b1; in_vec8 = 8'b1001_0110; out_ready8 = 1'b1;
        step();
        in_valid8 = 1'b0; in_vec8 = 8'h00;
        for (int k = 0; k < 4; k++) begin
            check_beat8($sformatf("msb%0d", k), exp_idx[k], exp_cnt[k], (k == 3) ? 32'd1 : 32'd0);
            step();
        end
        check_idle8("msb_done");

        // Backpressure on 0000_0011
        out_ready8 = 1'b0; in_valid8 = 1'b1; in_vec8 = 8'b0000_0011;
        step();
        in_valid8 = 1'b0; in_vec8 = 8'h00;
        for (int k = 0; k < 3; k++) begin
            check_beat8($sformatf("stall%0d", k), 32'd1, 32'd2, 32'd0);
            step();
        end
        out_ready8 = 1'b1;
        check_beat8("stall3", 32'd1, 32'd2, 32'd0);
        step();
        check_beat8("bp_last", 32'd0, 32'd1, 32'd1);
        step();
        check_idle8("bp_done");

        // Zero vector
        in_valid8 = 1'b1; in_vec8 = 8'h00;
        step();
        in_valid8 = 1'b0;
        check("zero_pulse", 32'(zero_det8), 32'd1);
        check_idle8("zero");
        step();
        check("zero_gone", 32'(zero_det8), 32'd0);
        check_idle8("zero_after");

        // Flush after two accepted beats of 8'hFF
        in_valid8 = 1'b1; in_vec8 = 8'hFF; out_ready8 = 1'b1;
        step();
        in_valid8 = 1'b0; in_vec8 = 8'h00;
        check_beat8("ff0", 32'd7, 32'd8, 32'd0);
        step();
        check_beat8("ff1", 32'd6, 32'd7, 32'd0);
        step();
        check_beat8("ff2", 32'd5, 32'd6, 32'd0);
        out_ready8 = 1'b0; flush8 = 1'b1;
        step();
        flush8 = 1'b0;
        check_idle8("flushed");
        in_valid8 = 1'b1; in_vec8 = 8'h01; out_ready8 = 1'b1;
        step();
        in_valid8 = 1'b0; in_vec8 = 8'h00;
        check_beat8("after_flush", 32'd0, 32'd1, 32'd1);
        step();
        check_idle8("after_flush_done");

        // flush in IDLE must not block a simultaneous load
        flush8 = 1'b1; in_valid8 = 1'b1; in_vec8 = 8'h04;
        step();
        flush8 = 1'b0; in_valid8 = 1'b0; in_vec8 = 8'h00;
        check_beat8("idle_flush", 32'd2, 32'd1, 32'd1);
        step();
        check_idle8("idle_flush_done");

        // LSB-first 16-bit scan of 16'h8001
        in_valid16 = 1'b1; in_vec16 = 16'h8001; out_ready16 = 1'b1;
        step();
        in_valid16 = 1'b0; in_vec16 = 16'h0000;
        check("lsb0_valid", 32'(out_valid16), 32'd1);
        check("lsb0_idx",   32'(out_idx16),   32'd0);
        check("lsb0_cnt",   32'(pend_cnt16),  32'd2);
        check("lsb0_last",  32'(out_last16),  32'd0);
        step();
        check("lsb1_idx",   32'(out_idx16),   32'd15);
        check("lsb1_cnt",   32'(pend_cnt16),  32'd1);
        check("lsb1_last",  32'(out_last16),  32'd1);
        step();
        check("lsb_done_valid", 32'(out_valid16), 32'd0);
        check("lsb_done_rdy",   32'(in_ready16),  32'd1);

        // Asynchronous reset in the middle of a scan of 1010_0000
        in_valid8 = 1'b1; in_vec8 = 8'b1010_0000; out_ready8 = 1'b1;
        step();
        in_valid8 = 1'b0; in_vec8 = 8'h00;
        check_beat8("mid0", 32'd7, 32'd2, 32'd0);
        step();
        check_beat8("mid1", 32'd5, 32'd1, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle8("async_rst");
        step();
        rst_n = 1'b1;
        step();
        check_idle8("rst_release");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
